sync_fifo: RTL and testbench

Parametrised single-clock FIFO with independent write and read handshakes, occupancy count and programmable almost-full/almost-empty thresholds. It succeeds the fixed two-entry shift FIFO. It is the general buffering primitive between producer and consumer stages in the same clock domain. Storage is a circular buffer with wrap-around read/write pointers, so depth scales without a data shift chain.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 96 +++++++++
 tb/tb_sync_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths, default parameters and parameter sanity check for the sync_fifo slice.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_AF_LEVEL   = 6;
  localparam int unsigned DEF_AE_LEVEL   = 2;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $unsigned($clog2(depth));
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $unsigned($clog2(depth)) + 32'd1;
  endfunction

  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned af_level,
                                   input int unsigned ae_level);
    return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0) &&
           (af_level >= 32'd1) && (af_level <= depth) &&
           (ae_level <= depth - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, synchronous read port with enable.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      re,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array is intentionally not reset; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with count and almost-full/empty thresholds.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_LEVEL   = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      wr,
  input  logic                      rd,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                      overflow,
  output logic                      underflow,
`endif
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo: DEPTH must be a power of two >= 2 and AF/AE levels in range");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance looks only at pre-edge occupancy, so wr/rd never bypass each other.
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky until reset; set on any request that the current state forces us to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: queue-based reference model, directed plus random traffic.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .wr           (wr),
    .rd           (rd),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue holding FIFO contents in order.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout = '0;
  bit            exp_ovf = 0;
  bit            exp_unf = 0;

  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      exp_q.delete();
      exp_dout = '0;
      exp_ovf  = 0;
      exp_unf  = 0;
    end else begin
      int  sz;
      bit  wa, ra;
      sz = model_q.size();
      wa = wr && (sz < int'(DEPTH));
      ra = rd && (sz > 0);
      if (wr && sz == int'(DEPTH)) exp_ovf = 1;
      if (rd && sz == 0) exp_unf = 1;
      if (ra) begin
        exp_dout = model_q.pop_front();
        exp_q.push_back(exp_dout);
      end
      if (wa) model_q.push_back(din);
    end
  end

  // Monitor: checks read data whenever a read was accepted, plus status every cycle.
  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    if (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      chk("read_data", int'(dout), int'(e));
    end
    chk("dout_hold", int'(dout), int'(exp_dout));
    chk("count", int'(count), sz);
    chk("full", int'(full), int'(sz == int'(DEPTH)));
    chk("empty", int'(empty), int'(sz == 0));
    chk("almost_full", int'(almost_full), int'(sz >= int'(AF)));
    chk("almost_empty", int'(almost_empty), int'(sz <= int'(AE)));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("underflow", int'(underflow), int'(exp_unf));
`endif
  end

  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    reset = 1'b0;
    cyc(0, 0, 8'h00);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_ae", int'(almost_empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_dout", int'(dout), 0);

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, DW'(i));
      if (i == 5) chk("af_after5", int'(almost_full), 0);
      if (i == 6) chk("af_after6", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);

    cyc(1, 0, 8'hAA);
    chk("full_wr_count", int'(count), 8);
`ifdef FIFO_ERR_FLAGS_EN
    chk("full_wr_ovf", int'(overflow), 1);
`endif

    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'h00);
      chk("drain_dout", int'(dout), i);
    end
    chk("drain_empty", int'(empty), 1);

    // Full with simultaneous wr&&rd.
    for (int i = 0; i < 8; i++) cyc(1, 0, DW'(8'h10 + i));
    cyc(1, 1, 8'h77);
    chk("full_wrrd_count", int'(count), 7);
    chk("full_wrrd_dout", int'(dout), 8'h10);
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'h00);
    chk("full_wrrd_last", int'(dout), 8'h17);

    // Empty with simultaneous wr&&rd.
    cyc(1, 1, 8'h5C);
    chk("empty_wrrd_count", int'(count), 1);
    chk("empty_wrrd_dout", int'(dout), 8'h17);
`ifdef FIFO_ERR_FLAGS_EN
    chk("empty_wrrd_unf", int'(underflow), 1);
`endif
    cyc(0, 1, 8'h00);
    chk("empty_wrrd_read", int'(dout), 8'h5C);

    // Random interleaved traffic with frequent zero data.
    for (int i = 0; i < 80; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end

    // Mid-operation reset with wr=rd=1.
    while (count != 0) cyc(0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 0, DW'(8'h40 + i));
    chk("pre_reset_count", int'(count), 5);
    reset = 1'b1;
    cyc(1, 1, 8'hEE);
    reset = 1'b0;
    chk("post_reset_count", int'(count), 0);
    chk("post_reset_empty", int'(empty), 1);
    chk("post_reset_dout", int'(dout), 0);
    cyc(1, 0, 8'h3C);
    cyc(0, 1, 8'h00);
    chk("post_reset_read", int'(dout), 8'h3C);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
